// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product dot-accumulator: FSM encoding,
// default widths and signed range helpers.
package booth_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  localparam int unsigned DEF_PROD_W = 8;
  localparam int unsigned DEF_ACC_W  = 12;
  localparam int unsigned DEF_LEN    = 4;

  function automatic longint smax(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint smin(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder: a (A_W bits) + sext(b) clamped to A_W bits.
module sat_add
  import booth_pkg::*;
#(
  parameter int unsigned A_W = DEF_ACC_W,
  parameter int unsigned B_W = DEF_PROD_W
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [A_W-1:0] sum,
  output logic                  sat_hit
);

  localparam logic signed [A_W-1:0] MAX = A_W'(smax(A_W));
  localparam logic signed [A_W-1:0] MIN = A_W'(smin(A_W));

  logic signed [A_W:0] wide;

  assign wide = {a[A_W-1], a} + {{(A_W + 1 - B_W){b[B_W-1]}}, b};

  // Out of range exactly when the two top bits of the widened sum disagree.
  always_comb begin
    sat_hit = wide[A_W] ^ wide[A_W-1];
    sum     = wide[A_W-1:0];
    if (sat_hit) sum = wide[A_W] ? MIN : MAX;
  end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Accumulates LEN signed products (one per rising edge of prod_valid) with
// saturation and reports one frame sum per completed frame.
module booth_dot_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned LEN    = DEF_LEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic signed [PROD_W-1:0]       prod,
  input  logic                           prod_valid,
  output logic signed [ACC_W-1:0]        acc_out,
  output logic                           acc_valid,
  output logic                           overflow,
  output logic [$clog2(LEN+1)-1:0]       count
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);

  state_t                  state, state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    sat_hit;
  logic                    ovf_int;
  logic                    prev_valid;
  logic                    accept;
  logic                    last;

  sat_add #(.A_W(ACC_W), .B_W(PROD_W)) u_sat_add (
    .a       (acc),
    .b       (prod),
    .sum     (sum),
    .sat_hit (sat_hit)
  );

  assign accept    = prod_valid & ~prev_valid;
  assign last      = (count == CNT_W'(LEN - 1));
  assign acc_valid = (state == ST_EMIT);

  always_comb begin
    state_next = ST_ACCUM;
    if (accept && last && !clear) state_next = ST_EMIT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACCUM;
    else       state <= state_next;
  end

  // prev_valid resets high so a valid held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid <= 1'b1;
      acc        <= '0;
      count      <= '0;
      ovf_int    <= 1'b0;
      acc_out    <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_valid <= prod_valid;
      if (clear) begin
        acc     <= '0;
        count   <= '0;
        ovf_int <= 1'b0;
      end else if (accept) begin
        if (last) begin
          acc_out  <= sum;
          overflow <= ovf_int | sat_hit;
          acc      <= '0;
          count    <= '0;
          ovf_int  <= 1'b0;
        end else begin
          acc     <= sum;
          count   <= count + CNT_W'(1);
          ovf_int <= ovf_int | sat_hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Self-checking bench: three configurations driven by shared stimulus, each
// compared every cycle against a queue-based frame model.
module tb_booth_dot_accumulator;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic signed [7:0] prod = '0;
  logic              prod_valid = 1'b0;

  logic signed [11:0] o0;
  logic signed [7:0]  o1, o2;
  logic               v0, v1, v2, f0, f1, f2;
  logic [2:0]         c0, c1;
  logic [0:0]         c2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(4)) d0 (
    .clk(clk), .reset(reset), .clear(clear), .prod(prod), .prod_valid(prod_valid),
    .acc_out(o0), .acc_valid(v0), .overflow(f0), .count(c0));

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(4)) d1 (
    .clk(clk), .reset(reset), .clear(clear), .prod(prod), .prod_valid(prod_valid),
    .acc_out(o1), .acc_valid(v1), .overflow(f1), .count(c1));

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(1)) d2 (
    .clk(clk), .reset(reset), .clear(clear), .prod(prod), .prod_valid(prod_valid),
    .acc_out(o2), .acc_valid(v2), .overflow(f2), .count(c2));

  // Reference model: a frame is a queue of accepted products, summed with a
  // clamp after every addition once it holds LEN entries.
  int aw[3] = '{12, 8, 8};
  int ln[3] = '{4, 4, 1};
  int frame[3][$];
  int exp_out[3];
  bit exp_v[3];
  bit exp_f[3];
  bit m_prev = 1'b1;
  bit chk_en = 1'b0;

  task automatic fold(input int q[$], input int w, output int s, output bit o);
    int mx, mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    s = 0;
    o = 1'b0;
    foreach (q[i]) begin
      s += q[i];
      if (s > mx) begin s = mx; o = 1'b1; end
      else if (s < mn) begin s = mn; o = 1'b1; end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      exp_v[k] = 1'b0;
      if (reset) begin
        frame[k].delete();
        exp_out[k] = 0;
        exp_f[k] = 1'b0;
      end else if (clear) begin
        frame[k].delete();
      end else if (prod_valid && !m_prev) begin
        frame[k].push_back(int'(prod));
        if (frame[k].size() == ln[k]) begin
          fold(frame[k], aw[k], exp_out[k], exp_f[k]);
          exp_v[k] = 1'b1;
          frame[k].delete();
        end
      end
    end
    m_prev = reset ? 1'b1 : prod_valid;
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic signed [31:0] o, input logic v,
                          input logic f, input logic [31:0] c);
    chk($sformatf("acc_out[%0d]", k), o, exp_out[k]);
    chk($sformatf("acc_valid[%0d]", k), {31'b0, v}, {31'b0, exp_v[k]});
    chk($sformatf("overflow[%0d]", k), {31'b0, f}, {31'b0, exp_f[k]});
    chk($sformatf("count[%0d]", k), c, frame[k].size());
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, 32'(o0), v0, f0, 32'(c0));
      cmp_inst(1, 32'(o1), v1, f1, 32'(c1));
      cmp_inst(2, 32'(o2), v2, f2, 32'(c2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int p);
    prod = 8'(p);
    prod_valid = 1'b1;
    cyc();
    prod_valid = 1'b0;
    cyc();
  endtask

  task automatic level(input int p);
    prod = 8'(p);
    prod_valid = 1'b1;
    repeat (5) cyc();
    prod_valid = 1'b0;
    cyc();
  endtask

  // Literal pins on both the DUT and the model.
  task automatic pin(input string nm, input logic signed [31:0] act, input int mdl, input int want);
    chk({nm, "_dut"}, act, want);
    chk({nm, "_model"}, mdl, want);
  endtask

  initial begin
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    pin("rst_out", 32'(o0), exp_out[0], 0);
    pin("rst_cnt", 32'(c0), frame[0].size(), 0);
    chk("rst_valid", {31'b0, v0}, 32'sd0);
    reset = 1'b0;
    cyc();

    // Pulsed frame; also lands in d1 unchanged (no saturation there).
    pulse(35); pulse(-24); pulse(15); pulse(-16);
    @(negedge clk);
    pin("t1_out", 32'(o0), exp_out[0], 10);
    pin("t1_out8", 32'(o1), exp_out[1], 10);
    pin("t1_cnt", 32'(c0), frame[0].size(), 0);

    level(35); level(1); level(1); level(1);
    @(negedge clk);
    pin("t2_out", 32'(o0), exp_out[0], 38);

    pulse(127); pulse(127); pulse(-1); pulse(0);
    @(negedge clk);
    pin("t3_out8", 32'(o1), exp_out[1], 126);
    pin("t3_ovf8", {31'b0, f1}, int'(exp_f[1]), 1);
    pin("t3_out12", 32'(o0), exp_out[0], 253);

    pulse(1); pulse(1); pulse(1); pulse(1);
    @(negedge clk);
    pin("t4_out8", 32'(o1), exp_out[1], 4);
    pin("t4_ovf8", {31'b0, f1}, int'(exp_f[1]), 0);

    repeat (4) pulse(-128);
    @(negedge clk);
    pin("t5_out8", 32'(o1), exp_out[1], -128);
    pin("t5_ovf8", {31'b0, f1}, int'(exp_f[1]), 1);
    pin("t5_out12", 32'(o0), exp_out[0], -512);

    // clear on the third edge drops the frame; previous result holds.
    pulse(5); pulse(6);
    prod = 8'sd7; prod_valid = 1'b1; clear = 1'b1;
    cyc();
    prod_valid = 1'b0; clear = 1'b0;
    cyc();
    @(negedge clk);
    pin("t6_hold", 32'(o0), exp_out[0], -512);
    pin("t6_cnt", 32'(c0), frame[0].size(), 0);
    pulse(1); pulse(2); pulse(3); pulse(4);
    @(negedge clk);
    pin("t6_out", 32'(o0), exp_out[0], 10);

    // reset mid-frame with valid held high across it.
    pulse(1); pulse(2); pulse(3);
    prod = 8'sd9; prod_valid = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    pin("t7_out", 32'(o0), exp_out[0], 0);
    pin("t7_cnt", 32'(c0), frame[0].size(), 0);
    prod_valid = 1'b0;
    cyc();
    pulse(7);
    @(negedge clk);
    pin("t7_cnt1", 32'(c0), frame[0].size(), 1);

    for (int n = 0; n < 800; n++) begin
      prod_valid = 1'($urandom_range(0, 1));
      prod = (n % 200 < 60) ? (($urandom_range(0, 1) == 1) ? 8'sd127 : -8'sd128) : 8'($urandom);
      clear = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    prod_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    repeat (3) cyc();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_dot_accumulator.md
# booth_dot_accumulator

Downstream consumer of the Booth's multiplier. Captures each signed product on the rising edge of the multiplier's `valid`, accumulates `LEN` products with saturating arithmetic, and emits one signed dot-product result per frame with a one-cycle strobe and a per-frame overflow flag. Sits between the multiplier's `Y`/`valid` outputs and any result sink, register bank or monitor.

## Interface
- `PROD_W`, default 8: width of the signed product input; matches the multiplier `Y`.
- `ACC_W`, default 12: width of the signed accumulator and result; must be ≥ `PROD_W`.
- `LEN`, default 4: number of products per frame; must be ≥ 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `clear`  in  1: synchronous frame abort; discards the partial frame.
- `prod`  in  `PROD_W`: signed product (multiplier `Y`).
- `prod_valid`  in  1: multiplier `valid`; only its 0→1 transition is meaningful.
- `acc_out`  out  `ACC_W`: signed saturated frame sum; holds until the next frame completes.
- `acc_valid`  out  1: one-cycle strobe, high when `acc_out` updates.
- `overflow`  out  1: saturation occurred anywhere in the reported frame; updates with `acc_out`.
- `count`  out  `clog2(LEN+1)`: products accepted in the current frame.

## Operation
- Accept condition: `prod_valid`=1 and `prev_valid`=0, where `prev_valid` is `prod_valid` registered. Accepting on the edge makes the block correct for both pulse and level `valid`. A level held high is counted once.
- On accept when `count` < `LEN`-1:
  - `acc` ← sat(`acc` + sext(`prod`)).
  - `count`++.
  - Sticky `ovf_int` |= sat_hit.
- On accept when `count` = `LEN`-1, the frame completes:
  - `acc_out` ← sat(`acc` + sext(`prod`)).
  - `overflow` ← `ovf_int` | sat_hit.
  - `acc_valid` ← 1.
  - `acc`, `count` and `ovf_int` ← 0.
- Saturation:
  - Compute the sum in `ACC_W`+1 bits.
  - If the sum is above 2^(`ACC_W`-1)-1, clamp to max. If it is below -2^(`ACC_W`-1), clamp to min.
  - sat_hit = 1 whenever a clamp occurs.
  - After a clamp, accumulation continues from the clamped value.
- `clear` (not `reset`):
  - `acc`, `count` and `ovf_int` ← 0.
  - `acc_out` and `overflow` keep their last reported values.
  - `acc_valid` ← 0.
  - `prev_valid` still tracks `prod_valid`.
- FSM states:
  - ACCUM: `count` < `LEN`, the resting state.
  - EMIT: the single cycle with `acc_valid`=1.
  - EMIT → ACCUM unconditionally. EMIT still accepts a new edge as the first product of the next frame.

## Timing
- Reset values: `acc_out`=0, `acc_valid`=0, `overflow`=0, `count`=0, internal `acc`=0, `ovf_int`=0, `prev_valid`=1. Setting `prev_valid` to 1 means a `valid` held high through reset is not counted.
- Accept latency: the product is absorbed at the edge where the accept condition holds. `count` is visible the next cycle.
- Result latency: `acc_out`/`overflow` update and `acc_valid` goes high in the cycle immediately after the `LEN`-th accepting edge. The strobe lasts exactly 1 cycle.
- Back-to-back: an accepted edge in the EMIT cycle starts the next frame. No product is lost.
- `clear` and accept in the same cycle: `clear` wins and the product is dropped. `clear` on the completing edge suppresses the result, and `acc_valid` stays 0.
- `reset` mid-frame: all state returns to reset values at that edge, and the partial frame is lost. `reset` has priority over `clear` and over accept.
- `LEN`=1: every accepted product produces an `acc_valid` strobe the next cycle, with `acc_out` = sat(sext(`prod`)).

## Structure
- Shared package `booth_pkg`:
  - FSM state encoding (`ST_ACCUM`, `ST_EMIT`).
  - Default `PROD_W`/`ACC_W`/`LEN` constants.
  - Signed min/max constant helpers.
- One sub-module, `sat_add`: parameterised signed saturating adder with outputs `sum` and `sat_hit`. It is combinational and instantiated once.
- Edge detect, counter, FSM and output registers live in `booth_dot_accumulator`.

## Test plan
- Defaults: products 35, -24, 15, -16 (5·7, -4·6, -3·-5, 2·-8), each as a 1-cycle `prod_valid` pulse → one `acc_valid` pulse the cycle after the 4th edge, `acc_out`=10, `overflow`=0, `count` returns to 0.
- Level `valid`: `prod_valid` held high 5 cycles with `prod`=35, then low; repeat three more times with 1, 1, 1 → `acc_out`=38, each level counted once.
- `ACC_W`=8: products 127, 127, -1, 0 → first add clamps to 127, then 126, then 126; `acc_out`=126, `overflow`=1. Next frame of 1, 1, 1, 1 → `acc_out`=4, `overflow`=0.
- `ACC_W`=8: four products of -128 → `acc_out`=-128, `overflow`=1.
- `clear` asserted in the same cycle as the 3rd edge of a frame, with 2 products already accepted → no strobe. The next 4 products 1, 2, 3, 4 → `acc_out`=10, and the earlier `acc_out` is held until then.
- `reset` after 3 products, with `prod_valid` held high across reset → all outputs 0 and no product counted until `prod_valid` falls and rises again.
